data_pack: RTL and testbench
============================

Name: data_pack

Overview:
- Downstream neighbour of data_unpack. Consumes its 7-bit sample stream (valid/data/sop/eop, no backpressure) and repacks the samples LSB-first into 32-bit words.
- Words are buffered in a small output FIFO and presented on a valid/ready interface to the next stage.
- Restores 32-bit framing with packet delimiters. Flags overflow when downstream stalls too long.

Parameters:
- DEPTH, 4, output FIFO depth in words (power of 2, >=2).

Ports:
- clk input 1 clock; all logic on the rising edge.
- rst input 1 reset, asynchronous, active-high.
- valid_in input 1 sample present this cycle (no ready; always accepted or discarded).
- data_in input 7 sample value.
- sop_in input 1 first sample of packet.
- eop_in input 1 last sample of packet.
- ready_in input 1 downstream can take a word.
- valid_out output 1 word presented.
- data_out output 32 packed word.
- sop_out output 1 word is first of packet.
- eop_out output 1 word is last of packet.
- overflow output 1 sticky: a word was dropped because the FIFO was full.
- err_sop output 1 sticky: sop_in arrived inside an open packet.

Behaviour:
- Reset (async, any time, including mid-packet):
  - State goes to IDLE; accumulator, bit count, pend register and FIFO are cleared.
  - All outputs are 0.
- FSM states:
  - IDLE: samples with sop_in=0 are discarded. A valid sample with sop_in=1 is accepted and moves the FSM to ACTIVE; if it also has eop_in=1, the FSM stays in IDLE.
  - ACTIVE: every valid sample is accepted. eop_in returns the FSM to IDLE. sop_in discards unemitted partial bits, sets err_sop, and restarts the packet with this sample; words already queued keep eop_out=0.
- Packing:
  - Accumulator is 39 bits with bit count 0..31 between samples.
  - Each sample is placed at bit offset = count.
  - When count+7 >= 32, the low 32 bits form a word and the remainder shifts down (count -= 25).
  - The first sample of a packet lands in bits [6:0]. A sample straddling a boundary splits: low bits go to the top of the current word, high bits to the bottom of the next word.
- eop flush:
  - The residual bits form a final word with upper bits zero.
  - eop is set on the last word produced. No empty word is produced when count ends at exactly 0 after the last full word.
  - The accumulator and count are cleared in the same cycle, so the next packet may start on the very next sample.
- Two words in one cycle: occurs when a full word and an eop residual are produced together.
  - The full word is written to the FIFO; the residual goes to the pend register (pend_valid=1).
  - Rule each cycle: the FIFO write port takes pend if pend_valid, otherwise the newly produced word. Any unwritten word is loaded into pend.
  - At most pend plus one new word can exist in a cycle, so no word is lost internally.
- sop_out is set on the first word pushed after an accepted sop; eop_out is set on the last word.
- Latency: a word completed by a sample accepted at edge N gives valid_out=1 after edge N (next cycle). A pend word appears one cycle later.
- FIFO:
  - Show-ahead; stores {sop, eop, data}. valid_out = not empty. Pop when valid_out && ready_in.
  - Push when full with a simultaneous pop succeeds.
  - Push when full without a pop drops that word and sets overflow.
  - overflow and err_sop stay set until reset.
- Throughput: sustains 1 sample per cycle indefinitely, including back-to-back packets and consecutive single-sample packets, provided ready_in is high.

Optional Feature:
- Macro DATA_PACK_STATS_EN.
- Defined: adds outputs pkt_cnt[15:0] (+1 per word pushed with eop) and drop_cnt[15:0] (+1 per dropped word). Both wrap at 16'hFFFF to 0 and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- 32 samples 7'h7F, sop on 1st, eop on 32nd, ready_in=1 -> 7 words 32'hFFFFFFFF, sop_out on 1st, eop_out on 7th only, no extra word.
- Single sample 7'h5A with sop_in=eop_in=1 -> one word 32'h0000005A, sop_out=eop_out=1, valid_out the cycle after.
- 5 samples 7'h7F (eop on 5th), then next cycle sop+eop sample 7'h12 -> words FFFFFFFF (sop), 00000007 (eop), 00000012 (sop+eop) on consecutive cycles; none lost.
- DEPTH=4, ready_in=0, 40 samples 7'h7F in one packet -> 4 words held, overflow=1 on 5th word, later words dropped; raise ready_in -> 4 words drain.
- Samples 7'h33 with sop_in=0 while IDLE, then sop sample 7'h01+eop -> only 32'h00000001 emitted.
- sop, 3 samples, then sop again without eop -> err_sop=1, partial discarded, new packet packs from bit 0; async rst mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/data_pack.sv
// Repacks a 7-bit sample stream LSB-first into 32-bit words behind a show-ahead output FIFO.
// Optional macro DATA_PACK_STATS_EN adds pkt_cnt/drop_cnt statistics outputs.
module data_pack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  data_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic        ready_in,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic        overflow,
  output logic        err_sop
`ifdef DATA_PACK_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_next;
  logic [38:0] acc, acc_next;
  logic [4:0]  cnt, cnt_next;
  logic        sop_pending, sop_pending_next;
  logic        pend_valid, pend_valid_next;
  logic [33:0] pend_word, pend_word_next;
  logic        err_sop_next;

  logic        accept, start, full_word, res_nz;
  logic [38:0] base_acc, sum;
  logic [4:0]  base_cnt;
  logic [5:0]  new_cnt;
  logic [31:0] res_data;
  logic        first_valid, second_valid, sop_now;
  logic [33:0] first_word, second_word;
  logic        push_req;
  logic [33:0] push_word;

  logic [33:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, fifo_full, pop, push_ok, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      sop_pending <= 1'b0;
      pend_valid  <= 1'b0;
      pend_word   <= '0;
      err_sop     <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      sop_pending <= sop_pending_next;
      pend_valid  <= pend_valid_next;
      pend_word   <= pend_word_next;
      err_sop     <= err_sop_next;
    end
  end

  // A sop sample always restarts packing from bit 0, discarding any open partial word.
  always_comb begin
    state_next       = state;
    acc_next         = acc;
    cnt_next         = cnt;
    sop_pending_next = sop_pending;
    err_sop_next     = err_sop;

    accept   = valid_in && ((state == ACTIVE) || sop_in);
    start    = accept && sop_in;
    base_acc = start ? 39'd0 : acc;
    base_cnt = start ? 5'd0 : cnt;
    sum      = base_acc | ({32'd0, data_in} << base_cnt);
    new_cnt  = {1'b0, base_cnt} + 6'd7;
    full_word = new_cnt[5];
    res_nz   = full_word ? (new_cnt[4:0] != 5'd0) : 1'b1;
    res_data = full_word ? {25'd0, sum[38:32]} : sum[31:0];
    sop_now  = sop_pending || start;

    first_valid  = accept && (full_word || (eop_in && res_nz));
    second_valid = accept && full_word && eop_in && res_nz;
    first_word   = full_word ? {sop_now, eop_in && !res_nz, sum[31:0]}
                             : {sop_now, 1'b1, res_data};
    second_word  = {1'b0, 1'b1, res_data};

    if (valid_in && sop_in && (state == ACTIVE))
      err_sop_next = 1'b1;

    if (accept) begin
      state_next = eop_in ? IDLE : ACTIVE;
      if (eop_in) begin
        acc_next = '0;
        cnt_next = '0;
      end else if (full_word) begin
        acc_next = {32'd0, sum[38:32]};
        cnt_next = new_cnt[4:0];
      end else begin
        acc_next = sum;
        cnt_next = new_cnt[4:0];
      end
    end

    if (first_valid)
      sop_pending_next = 1'b0;
    else if (start)
      sop_pending_next = 1'b1;

    // The pending word always goes first so words leave in production order.
    push_req        = pend_valid || first_valid;
    push_word       = pend_valid ? pend_word : first_word;
    pend_valid_next = pend_valid ? first_valid : second_valid;
    pend_word_next  = pend_valid ? first_word : second_word;
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && ready_in;
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)    overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign valid_out = !empty;
  assign sop_out   = valid_out && mem[rd_ptr[AW-1:0]][33];
  assign eop_out   = valid_out && mem[rd_ptr[AW-1:0]][32];
  assign data_out  = valid_out ? mem[rd_ptr[AW-1:0]][31:0] : 32'd0;

`ifdef DATA_PACK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok && push_word[32]) pkt_cnt <= pkt_cnt + 16'd1;
      if (drop) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_pack.sv
// Scoreboard bench for data_pack: stimulus queues expected words, a monitor pops and compares.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [6:0]  data_in = '0;
  logic        sop_in = 1'b0;
  logic        eop_in = 1'b0;
  logic        ready_in = 1'b1;
  logic        valid_out;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        overflow;
  logic        err_sop;
`ifdef DATA_PACK_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [33:0] exp_q[$];
  int pop_cycles[$];

  data_pack #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out),
    .overflow(overflow), .err_sop(err_sop)
`ifdef DATA_PACK_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] d, input logic s, input logic e);
    valid_in = 1'b1;
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  task automatic expectWord(input logic s, input logic e, input logic [31:0] d);
    exp_q.push_back({s, e, d});
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every accepted handshake is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      pop_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word: got %0h expected none", {sop_out, eop_out, data_out});
      end else begin
        checkOutput("word", 64'({sop_out, eop_out, data_out}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #12;
    checkOutput("reset_outputs", 64'({valid_out, sop_out, eop_out, data_out, overflow, err_sop}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 32 full samples pack into exactly 7 all-ones words.
    $display("[TB] test: 32 samples of 7f");
    expectWord(1'b1, 1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) expectWord(1'b0, 1'b0, 32'hFFFFFFFF);
    expectWord(1'b0, 1'b1, 32'hFFFFFFFF);
    for (int i = 1; i <= 32; i++) applyStimulus(7'h7F, i == 1, i == 32);
    waitDrain("drain_32");
    idleCycles(3);
    checkOutput("no_extra_word", 64'(valid_out), 64'd0);

    // Single-sample packet appears the cycle after acceptance.
    $display("[TB] test: single sample packet");
    ready_in = 1'b0;
    expectWord(1'b1, 1'b1, 32'h0000005A);
    applyStimulus(7'h5A, 1'b1, 1'b1);
    checkOutput("single_latency", 64'({valid_out, sop_out, eop_out, data_out}), 64'({3'b111, 32'h0000005A}));
    ready_in = 1'b1;
    waitDrain("drain_single");

    // Full word plus eop residual in one cycle, then a back-to-back packet.
    $display("[TB] test: two words in one cycle");
    pop_cycles.delete();
    expectWord(1'b1, 1'b0, 32'hFFFFFFFF);
    expectWord(1'b0, 1'b1, 32'h00000007);
    expectWord(1'b1, 1'b1, 32'h00000012);
    for (int i = 1; i <= 5; i++) applyStimulus(7'h7F, i == 1, i == 5);
    applyStimulus(7'h12, 1'b1, 1'b1);
    waitDrain("drain_pend");
    checkOutput("pop_count_pend", 64'(pop_cycles.size()), 64'd3);
    if (pop_cycles.size() == 3) begin
      checkOutput("consecutive_1", 64'(pop_cycles[1] - pop_cycles[0]), 64'd1);
      checkOutput("consecutive_2", 64'(pop_cycles[2] - pop_cycles[1]), 64'd1);
    end

    // Stalled downstream: four words held, the fifth is dropped.
    $display("[TB] test: overflow");
    ready_in = 1'b0;
    expectWord(1'b1, 1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) expectWord(1'b0, 1'b0, 32'hFFFFFFFF);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(7'h7F, i == 1, i == 40);
      if (i == 22) checkOutput("overflow_before", 64'(overflow), 64'd0);
      if (i == 23) checkOutput("overflow_set", 64'(overflow), 64'd1);
    end
    ready_in = 1'b1;
    waitDrain("drain_overflow");
    idleCycles(2);
    checkOutput("overflow_sticky", 64'({overflow, valid_out}), 64'b10);
`ifdef DATA_PACK_STATS_EN
    checkOutput("drop_cnt", 64'(drop_cnt), 64'd5);
`endif

    rst = 1'b1;
    idleCycles(1);
    checkOutput("overflow_cleared", 64'(overflow), 64'd0);
    rst = 1'b0;
    idleCycles(1);

    // Samples without sop while idle are ignored.
    $display("[TB] test: idle discard");
    expectWord(1'b1, 1'b1, 32'h00000001);
    for (int i = 0; i < 3; i++) applyStimulus(7'h33, 1'b0, 1'b0);
    applyStimulus(7'h01, 1'b1, 1'b1);
    waitDrain("drain_idle");

    // sop inside an open packet restarts packing from bit 0.
    $display("[TB] test: sop restart");
    expectWord(1'b1, 1'b1, 32'h00001515);
    applyStimulus(7'h01, 1'b1, 1'b0);
    applyStimulus(7'h02, 1'b0, 1'b0);
    applyStimulus(7'h03, 1'b0, 1'b0);
    checkOutput("err_sop_clear", 64'(err_sop), 64'd0);
    applyStimulus(7'h15, 1'b1, 1'b0);
    checkOutput("err_sop_set", 64'(err_sop), 64'd1);
    applyStimulus(7'h2A, 1'b0, 1'b1);
    waitDrain("drain_restart");

    // Asynchronous reset while a word is queued and a packet is open.
    $display("[TB] test: async reset");
    ready_in = 1'b0;
    for (int i = 1; i <= 6; i++) applyStimulus(7'h7F, i == 1, 1'b0);
    checkOutput("queued_before_reset", 64'(valid_out), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", 64'({valid_out, sop_out, eop_out, data_out, overflow, err_sop}), 64'd0);
    idleCycles(1);
    rst = 1'b0;
    ready_in = 1'b1;
    idleCycles(3);
    checkOutput("post_reset_idle", 64'(valid_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
